// File: rtl/vp_seq_pkg.sv
// Shared definitions for the vector-processor command sequencer:
// command width, opcode constants, FSM state type and an opcode legality helper.
package vp_seq_pkg;

    localparam int CMD_W = 13;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_GAP
    } state_t;

    // True for opcodes the processor understands; 010, 101 and 111 are reserved.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/vp_cmd_fifo.sv
// Command FIFO for the sequencer: DEPTH entries (power of two), wrapping
// pointers, registered occupancy. Never overwrites: pushes on full and pops
// on empty are ignored.
module vp_cmd_fifo
    import vp_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [CMD_W-1:0]       din,
    output logic [CMD_W-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; pointer width equals log2(DEPTH) so they wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage write; nothing is stored in a reset cycle.
    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vp_cmd_sequencer.sv
// Command sequencer: queues host commands and, after a start request,
// pulses set once and then issues one queued command per cycle to the
// vector processor, inserting MUL_GAP NOP cycles after every multiply.
// Reserved opcodes are dropped (a zero slot is issued instead).
// Optional feature: define VP_SEQ_ISSUE_COUNT_EN to add issued_count.
module vp_cmd_sequencer
    import vp_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_GAP = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [12:0]            cmd_in,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic                   set,
    output logic [12:0]            instruction_set,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef VP_SEQ_ISSUE_COUNT_EN
    ,
    output logic [15:0]            issued_count
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [2:0]    GAP_LOAD = 3'(MUL_GAP);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       gap_cnt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CMD_W-1:0] head;
    logic [2:0]       head_op;
    logic             head_legal;
    logic             busy_nxt;

    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign head_op    = head[12:10];
    assign head_legal = op_is_legal(head_op);

    vp_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .head  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and pop decision; a MUL only opens a gap when MUL_GAP is non-zero.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_INIT;
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if ((head_op == OP_MUL) && (MUL_GAP != 0)) state_nxt = ST_GAP;
                end
            end
            ST_GAP:  if (gap_cnt <= 3'd1) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gap counter: loaded when a multiply is issued, counts down through GAP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if ((state == ST_RUN) && (state_nxt == ST_GAP)) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Busy reflects the state and occupancy that will hold after this edge.
    always_comb begin
        busy_nxt = (state_nxt != ST_IDLE) || push || (fifo_level > LVL_ONE) ||
                   ((fifo_level == LVL_ONE) && !pop);
    end

    // Registered outputs: set pulse on start from IDLE, popped command one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            set             <= 1'b0;
            instruction_set <= '0;
            busy            <= 1'b0;
        end else begin
            set             <= (state == ST_IDLE) && start;
            instruction_set <= (pop && head_legal) ? head : '0;
            busy            <= busy_nxt;
        end
    end

`ifdef VP_SEQ_ISSUE_COUNT_EN
    // Count real issued work: legal, non-NOP commands; wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_count <= '0;
        end else if (pop && head_legal && (head_op != OP_NOP)) begin
            issued_count <= issued_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vp_cmd_sequencer.sv
// Self-checking bench for vp_cmd_sequencer (DEPTH=4, MUL_GAP=2).
// A queue-based model predicts every registered output; directed
// sequences add literal expectations at the interesting cycles.
module tb_vp_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int MUL_GAP = 2;
    localparam int LW      = $clog2(DEPTH) + 1;

    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_GAP  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [12:0]   cmd_in;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          set;
    logic [12:0]   instruction_set;
    logic          busy;
    logic [LW-1:0] fifo_level;
`ifdef VP_SEQ_ISSUE_COUNT_EN
    logic [15:0]   issued_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vp_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .MUL_GAP (MUL_GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cmd_in          (cmd_in),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .set             (set),
        .instruction_set (instruction_set),
        .busy            (busy),
        .fifo_level      (fifo_level)
`ifdef VP_SEQ_ISSUE_COUNT_EN
        ,
        .issued_count    (issued_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] op);
        return op inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b110};
    endfunction

    // Behavioural model: session phase, a command queue and a stall count.
    logic [12:0] q[$];
    int          phase = P_IDLE;
    int          stall = 0;
    bit          model_ok = 1'b0;
    logic        exp_set;
    logic [12:0] exp_instr;
    logic        exp_busy;
    int          exp_level;
    int          exp_cnt;

    always @(posedge clk) begin
        bit          acc;
        logic [12:0] c;
        if (!reset) begin
            q.delete();
            phase     = P_IDLE;
            stall     = 0;
            exp_set   = 1'b0;
            exp_instr = '0;
            exp_busy  = 1'b0;
            exp_level = 0;
            exp_cnt   = 0;
            model_ok  = 1'b1;
        end else begin
            acc       = cmd_valid && (q.size() < DEPTH);
            exp_set   = 1'b0;
            exp_instr = '0;
            case (phase)
                P_IDLE: if (start) begin phase = P_INIT; exp_set = 1'b1; end
                P_INIT: phase = P_RUN;
                P_GAP: begin
                    stall--;
                    if (stall == 0) phase = P_RUN;
                end
                default: begin
                    if (q.size() != 0) begin
                        c = q.pop_front();
                        if (legal(c[12:10])) begin
                            exp_instr = c;
                            if (c[12:10] != 3'b000) exp_cnt = (exp_cnt + 1) % 65536;
                        end
                        if (c[12:10] == 3'b110 && MUL_GAP > 0) begin
                            phase = P_GAP;
                            stall = MUL_GAP;
                        end
                    end
                end
            endcase
            if (acc) q.push_back(cmd_in);
            exp_level = q.size();
            exp_busy  = (phase != P_IDLE) || (q.size() != 0);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_set", set, exp_set);
            check("m_instruction_set", instruction_set, exp_instr);
            check("m_busy", busy, exp_busy);
            check("m_fifo_level", fifo_level, exp_level);
            check("m_cmd_ready", cmd_ready, exp_level != DEPTH);
`ifdef VP_SEQ_ISSUE_COUNT_EN
            check("m_issued_count", issued_count, exp_cnt);
`endif
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [12:0] w [5];
`ifdef VP_SEQ_ISSUE_COUNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt_delta;
`endif

    initial begin
        w[0] = 13'h0401; w[1] = 13'h0C02; w[2] = 13'h1003; w[3] = 13'h0005; w[4] = 13'h0406;

        // Reset cycle with a push attempt that must not be stored.
        reset = 1'b0; start = 1'b0; cmd_valid = 1'b1; cmd_in = 13'h0C00;
        cyc();
        reset = 1'b1; cmd_valid = 1'b0;
        check("rst_level", fifo_level, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_set", set, 0);
        check("rst_instr", instruction_set, 0);

        // Queue three commands in IDLE, then start.
        cmd_valid = 1'b1;
        cmd_in = 13'h0C00; cyc();
        cmd_in = 13'h0600; cyc();
        cmd_in = 13'h1000; cyc();
        cmd_valid = 1'b0;
        check("idle_level", fifo_level, 3);
        check("idle_busy", busy, 1);
        check("idle_set", set, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check("init_set", set, 1);
        check("init_instr", instruction_set, 0);
        cyc();
        check("run_set_drop", set, 0);
        check("run_first_zero", instruction_set, 0);
        cyc(); check("issue_0c00", instruction_set, 13'h0C00);
        cyc(); check("issue_0600", instruction_set, 13'h0600);
        cyc(); check("issue_1000", instruction_set, 13'h1000);
        start = 1'b1; cyc(); start = 1'b0;
        check("drained_zero", instruction_set, 0);
        check("start_in_run", set, 0);

        // Multiply gap of two NOP slots.
        cmd_valid = 1'b1;
        cmd_in = 13'h1800; cyc();
        cmd_in = 13'h1000; cyc();
        cmd_valid = 1'b0;
        check("mul_issue", instruction_set, 13'h1800);
        cyc(); check("gap_slot0", instruction_set, 0);
        cyc(); check("gap_slot1", instruction_set, 0);
        cyc(); check("after_gap", instruction_set, 13'h1000);

        // Reserved opcode is dropped.
`ifdef VP_SEQ_ISSUE_COUNT_EN
        cnt0 = issued_count;
`endif
        cmd_valid = 1'b1;
        cmd_in = 13'h1400; cyc();
        cmd_in = 13'h0600; cyc();
        cmd_valid = 1'b0;
        check("reserved_slot", instruction_set, 0);
        cyc(); check("post_reserved", instruction_set, 13'h0600);
`ifdef VP_SEQ_ISSUE_COUNT_EN
        cnt_delta = issued_count - cnt0;
        check("count_delta", cnt_delta, 1);
`endif

        // Reset in the middle of a gap with two commands queued.
        cmd_valid = 1'b1;
        cmd_in = 13'h1800; cyc();
        cmd_in = 13'h0C00; cyc();
        cmd_in = 13'h0600; cyc();
        cmd_valid = 1'b0;
        check("gap_level", fifo_level, 2);
        check("gap_instr", instruction_set, 0);
        reset = 1'b0; cyc(); reset = 1'b1;
        check("abort_set", set, 0);
        check("abort_instr", instruction_set, 0);
        check("abort_busy", busy, 0);
        check("abort_level", fifo_level, 0);
        check("abort_ready", cmd_ready, 1);
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_set", set, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("no_stale_cmd", instruction_set, 0);
        end

        // Fill the FIFO in IDLE; the fifth word waits for the first pop.
        reset = 1'b0; cyc(); reset = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_in = w[i];
            cyc();
        end
        check("full_ready", cmd_ready, 0);
        check("full_level", fifo_level, 4);
        cmd_in = w[4];
        cyc(2);
        check("held_level", fifo_level, 4);
        start = 1'b1; cyc(); start = 1'b0;
        check("init_full_level", fifo_level, 4);
        cyc();
        check("run_full_level", fifo_level, 4);
        check("run_full_ready", cmd_ready, 0);
        cyc();
        check("first_pop_level", fifo_level, 3);
        check("first_pop_out", instruction_set, w[0]);
        check("first_pop_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        check("push_pop_level", fifo_level, 3);
        check("out_w1", instruction_set, w[1]);
        cyc(); check("out_w2", instruction_set, w[2]);
        cyc(); check("out_w3", instruction_set, w[3]);
        cyc(); check("out_w4", instruction_set, w[4]);
        cyc();
        check("final_zero", instruction_set, 0);
        check("final_level", fifo_level, 0);
        check("final_busy", busy, 1);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
